// File: rtl/stage_fifo_reader.sv
// Read-side controller for a ray-pipeline stage FIFO.
// Fetches from synchronous storage and drives a valid/ready output.
`ifndef STAGE_FIFO_SIZE_WIDTH
`define STAGE_FIFO_SIZE_WIDTH 4
`endif

module stage_fifo_reader #(
  parameter int WIDTH  = `STAGE_FIFO_SIZE_WIDTH,
  parameter int SIZE   = 2**WIDTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  i_bottom,
  input  logic              i_flush,
  output logic [WIDTH-1:0]  o_top,
  output logic              o_rd_en,
  output logic [WIDTH-1:0]  o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_empty,
  output logic [WIDTH-1:0]  o_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] top_nxt;
  logic             rd_en;

  assign o_top     = top;
  assign o_rd_addr = top;
  assign o_empty   = (top == i_bottom);
  assign o_count   = i_bottom - top;
  assign o_rd_en   = rd_en;

  // Slot is released at issue: the RAM latches the address this edge.
  always_comb begin
    rd_en   = 1'b0;
    top_nxt = top + 1'b1;
    if (top == WIDTH'(SIZE - 1))
      top_nxt = '0;
    if (resetn && !i_flush && !o_empty)
      rd_en = (state == IDLE) ||
              (state == VALID && i_ready);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      top     <= '0;
      state   <= IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_flush) begin
      top     <= i_bottom;
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      if (rd_en)
        top <= top_nxt;
      unique case (state)
        IDLE: begin
          if (rd_en)
            state <= FETCH;
        end
        FETCH: begin
          o_data  <= i_rd_data;
          o_valid <= 1'b1;
          state   <= VALID;
        end
        VALID: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= o_empty ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_fifo_reader.sv
// Directed bench for stage_fifo_reader.
// Storage RAM is modelled locally with one-cycle read latency.
module tb_stage_fifo_reader;

  logic        clk;
  logic        resetn;
  logic [3:0]  i_bottom;
  logic        i_flush;
  logic [3:0]  o_top;
  logic        o_rd_en;
  logic [3:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic        o_valid;
  logic [31:0] o_data;
  logic        i_ready;
  logic        o_empty;
  logic [3:0]  o_count;

  logic [31:0] mem [16];
  int n_assert;
  int n_fail;

  stage_fifo_reader #(
    .WIDTH(4),
    .SIZE(16),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .i_bottom(i_bottom),
    .i_flush(i_flush),
    .o_top(o_top),
    .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data),
    .o_valid(o_valid),
    .o_data(o_data),
    .i_ready(i_ready),
    .o_empty(o_empty),
    .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_rd_en)
      i_rd_data <= mem[o_rd_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    i_rd_data = '0;
    for (int i = 0; i < 16; i++)
      mem[i] = 32'hA5A0_0000 + 32'(i * 17) + 32'h100;
    resetn   = 1'b0;
    i_bottom = '0;
    i_flush  = 1'b0;
    i_ready  = 1'b0;

    // reset then idle
    step();
    step();
    chk("rst_top", 32'(o_top), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_data", o_data, 32'd0);
    resetn = 1'b1;
    step();
    chk("idle_rden", 32'(o_rd_en), 32'd0);

    // single entry
    i_bottom = 4'd1;
    i_ready  = 1'b1;
    #1;
    chk("s_rden", 32'(o_rd_en), 32'd1);
    chk("s_addr", 32'(o_rd_addr), 32'd0);
    chk("s_count", 32'(o_count), 32'd1);
    step();
    chk("s_top", 32'(o_top), 32'd1);
    chk("s_fetch_valid", 32'(o_valid), 32'd0);
    step();
    chk("s_valid", 32'(o_valid), 32'd1);
    chk("s_data", o_data, mem[0]);
    step();
    chk("s_done_valid", 32'(o_valid), 32'd0);
    chk("s_done_empty", 32'(o_empty), 32'd1);

    // burst with backpressure
    resetn   = 1'b0;
    i_bottom = 4'd0;
    i_ready  = 1'b0;
    step();
    resetn   = 1'b1;
    i_bottom = 4'd5;
    #1;
    chk("b_rden", 32'(o_rd_en), 32'd1);
    step();
    step();
    chk("b_count", 32'(o_count), 32'd4);
    for (int k = 0; k < 3; k++) begin
      chk("b_hold_valid", 32'(o_valid), 32'd1);
      chk("b_hold_data", o_data, mem[0]);
      chk("b_hold_rden", 32'(o_rd_en), 32'd0);
      step();
    end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("b_valid", 32'(o_valid), 32'd1);
      chk("b_data", o_data, mem[k]);
      chk("b_rden", 32'(o_rd_en), (k < 4) ? 32'd1 : 32'd0);
      step();
      chk("b_gap", 32'(o_valid), 32'd0);
      if (k < 4) step();
    end
    chk("b_top", 32'(o_top), 32'd5);
    chk("b_empty", 32'(o_empty), 32'd1);

    // wrap-around from top=14
    i_ready  = 1'b0;
    i_bottom = 4'd14;
    i_flush  = 1'b1;
    step();
    i_flush  = 1'b0;
    chk("w_top", 32'(o_top), 32'd14);
    i_bottom = 4'd2;
    i_ready  = 1'b1;
    #1;
    chk("w_count", 32'(o_count), 32'd4);
    chk("w_rden", 32'(o_rd_en), 32'd1);
    chk("w_addr0", 32'(o_rd_addr), 32'd14);
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      chk("w_valid", 32'(o_valid), 32'd1);
      chk("w_data", o_data, mem[(14 + k) % 16]);
      if (k < 3)
        chk("w_addr", 32'(o_rd_addr), 32'((15 + k) % 16));
      else
        chk("w_last_rden", 32'(o_rd_en), 32'd0);
    end
    step();
    chk("w_end_top", 32'(o_top), 32'd2);
    chk("w_end_empty", 32'(o_empty), 32'd1);
    chk("w_end_valid", 32'(o_valid), 32'd0);

    // flush during fetch
    i_ready  = 1'b0;
    i_bottom = 4'd7;
    #1;
    chk("f_rden", 32'(o_rd_en), 32'd1);
    step();
    chk("f_fetch_top", 32'(o_top), 32'd3);
    i_flush = 1'b1;
    #1;
    chk("f_flush_rden", 32'(o_rd_en), 32'd0);
    step();
    i_flush = 1'b0;
    chk("f_valid", 32'(o_valid), 32'd0);
    chk("f_top", 32'(o_top), 32'd7);
    chk("f_empty", 32'(o_empty), 32'd1);
    step();
    chk("f_no_present", 32'(o_valid), 32'd0);
    chk("f_data_kept", o_data, mem[1]);

    // full boundary: top=5, bottom=4
    i_bottom = 4'd5;
    i_flush  = 1'b1;
    step();
    i_flush  = 1'b0;
    chk("full_top", 32'(o_top), 32'd5);
    i_bottom = 4'd4;
    #1;
    chk("full_count", 32'(o_count), 32'd15);
    chk("full_cond", 32'(o_top - i_bottom), 32'd1);
    chk("full_addr", 32'(o_rd_addr), 32'd5);
    step();
    chk("full_freed_top", 32'(o_top), 32'd6);
    chk("full_freed_count", 32'(o_count), 32'd14);

    // reset during fetch discards returning data
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rf_valid", 32'(o_valid), 32'd0);
    chk("rf_data", o_data, 32'd0);
    chk("rf_top", 32'(o_top), 32'd0);
    step();
    chk("rf_no_present", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage_fifo_reader.md
Name: stage_fifo_reader

Overview:
- Read-side controller for a ray-pipeline stage FIFO; counterpart to the writer-side full check.
- Owns the read pointer `top`, which marks the oldest entry. The writer owns the write pointer `bottom`.
- Fetches entries from the stage FIFO's synchronous storage RAM and presents them downstream on a valid/ready interface.
- Reports empty status and occupancy back to the writer side and to stage control.

Parameters:
- WIDTH, default `STAGE_FIFO_SIZE_WIDTH` (4): pointer width.
- SIZE, default 2**WIDTH: number of slots. Usable capacity is SIZE-1.
- DATA_W, default 32: width of one FIFO entry.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- i_bottom  in  WIDTH  writer's write pointer; next slot the writer fills.
- i_flush  in  1  discard all queued entries and any held output.
- o_top  out  WIDTH  read pointer; fed to the writer's full check.
- o_rd_en  out  1  storage read strobe (combinational).
- o_rd_addr  out  WIDTH  storage read address; always equals o_top (combinational).
- i_rd_data  in  DATA_W  storage read data; valid one cycle after o_rd_en.
- o_valid  out  1  downstream data valid.
- o_data  out  DATA_W  downstream data.
- i_ready  in  1  downstream accepts.
- o_empty  out  1  (o_top == i_bottom) (combinational).
- o_count  out  WIDTH  (i_bottom - o_top) mod SIZE (combinational); excludes the entry held in o_data.

Behaviour:
- Reset (resetn=0 at an edge):
  - top=0, state=IDLE, o_valid=0, o_data=0.
  - Reset overrides i_flush and any in-flight fetch. A returning i_rd_data is ignored.
- Pointer semantics:
  - FIFO is empty when top == bottom.
  - Writer-side full is (top - bottom) mod SIZE == 1.
  - top increments mod SIZE, wrapping SIZE-1 -> 0. No extra wrap bit.
- Slot release: top advances in the same cycle o_rd_en is asserted, so the slot is freed on issue. The RAM captures the address at that edge, so a writer reusing the slot from the next cycle on is safe.
- FSM states:
  - IDLE: o_valid=0.
    - If !o_empty: o_rd_en=1, top<=top+1, go to FETCH.
    - Else stay in IDLE.
  - FETCH: o_rd_en=0. o_data<=i_rd_data, o_valid<=1, go to VALID.
  - VALID: o_valid=1, o_data held stable while i_ready=0.
    - On i_ready=1 with !o_empty: issue next read in the same cycle (o_rd_en=1, top<=top+1), go to FETCH, o_valid<=0.
    - On i_ready=1 with o_empty: go to IDLE, o_valid<=0.
- Latency and throughput:
  - First entry: bottom advances in cycle N, so o_empty=0 in cycle N. Read issued in N, o_valid high in N+2.
  - Sustained throughput is one entry per 2 cycles.
- i_bottom is used combinationally and may change any cycle. An entry written in the same cycle the reader samples empty is picked up in the following cycle.
- Flush (i_flush=1, resetn=1):
  - top<=i_bottom, o_valid<=0, state<=IDLE, o_rd_en=0 that cycle.
  - Takes priority over a handshake and over a FETCH capture. No entry is delivered for that cycle or a pending fetch.
- o_valid never drops without a handshake, except on flush or reset.
- o_data is only updated on entry to VALID.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles with i_bottom=0 -> o_top=0, o_valid=0, o_empty=1, o_count=0.
- Single entry, WIDTH=4: i_bottom 0->1 at cycle N, i_ready=1 -> o_rd_en=1 with o_rd_addr=0 in N; o_top=1 at N+1; o_valid=1 with o_data=RAM[0] at N+2; o_valid=0 at N+3; o_empty=1.
- Burst and backpressure: preload 5 entries (i_bottom=5), hold i_ready=0 -> o_valid stays 1 with RAM[0] stable, o_count=4. Release i_ready -> RAM[0..4] delivered in order, one every 2 cycles, final o_top=5.
- Wrap-around: top=14, i_bottom=2 -> o_count=4. Drain gives read addresses 14,15,0,1, ending with o_top=2 and o_empty=1.
- Flush mid-fetch: in FETCH with i_bottom=7, o_top=3, assert i_flush -> next cycle o_valid=0, o_top=7, state IDLE, and the fetched data is never presented.
- Full boundary: top=5, i_bottom=4 -> o_count=15 (capacity). One handshake frees slot 5, so the writer sees not-full the next cycle.
